rotate_seq_unit: RTL and testbench

ROTATE_SEQ_UNIT -- requirements
Module: rotate_seq_unit

---
 rtl/rotate_seq_pkg.sv | 14 +
 rtl/rotate_seq_unit_rot_reg.sv | 34 +++
 rtl/rotate_seq_unit.sv | 104 ++++++++++
 tb/tb_rotate_seq_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rotate_seq_pkg.sv
// Shared definitions for the rotate sequencer: one-hot FSM state encoding
// and rotate-direction constants.
package rotate_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        ROTATE = 3'b010,
        OUTPUT = 3'b100
    } state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/rotate_seq_unit_rot_reg.sv
// Rotating data register: loads an operand, then rotates it one bit per
// cycle left or right with end-around wrap. Load wins over either rotate.
module rot_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             rot_left,
    input  logic             rot_right,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Operand register with load / single-step rotate
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {WIDTH{1'b0}};
        end else if (load) begin
            q_r <= d;
        end else if (rot_left) begin
            q_r <= {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        end else if (rot_right) begin
            q_r <= {q_r[0], q_r[WIDTH-1:1]};
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/rotate_seq_unit.sv
// Sequential rotator: captures an operand, rotates it one bit per cycle for
// the requested step count, then presents the result until accepted.
module rotate_seq_unit
    import rotate_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir,
    input  logic [AMT_W-1:0] amount,
    input  logic             out_ready,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out
);

    state_e           state_r;
    logic [AMT_W-1:0] cnt_r;
    logic             dir_r;
    logic             load_s;
    logic             rot_left_s;
    logic             rot_right_s;
    logic [WIDTH-1:0] reg_q_s;

    // Datapath controls decoded from the current state
    always_comb begin
        load_s      = 1'b0;
        rot_left_s  = 1'b0;
        rot_right_s = 1'b0;
        case (state_r)
            IDLE: begin
                load_s = start;
            end
            ROTATE: begin
                rot_left_s  = (dir_r == DIR_LEFT);
                rot_right_s = (dir_r == DIR_RIGHT);
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Control FSM and step counter; a zero amount skips straight to OUTPUT
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {AMT_W{1'b0}};
            dir_r   <= DIR_RIGHT;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        dir_r   <= dir;
                        cnt_r   <= amount;
                        state_r <= (amount != {AMT_W{1'b0}}) ? ROTATE : OUTPUT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ROTATE: begin
                    cnt_r <= cnt_r - AMT_W'(1);
                    if (cnt_r == AMT_W'(1)) begin
                        state_r <= OUTPUT;
                    end else begin
                        state_r <= ROTATE;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= OUTPUT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    rot_reg #(
        .WIDTH(WIDTH)
    ) u_rot_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .rot_left (rot_left_s),
        .rot_right(rot_right_s),
        .d        (data_in),
        .q        (reg_q_s)
    );

    // Outputs depend only on state and the data register
    assign busy      = (state_r != IDLE);
    assign out_valid = (state_r == OUTPUT);
    assign data_out  = (state_r == OUTPUT) ? reg_q_s : {WIDTH{1'b0}};

endmodule

// File: tb/tb_rotate_seq_unit.sv
// Self-checking bench for rotate_seq_unit: directed cases plus randomized
// operations checked against an arithmetic rotate model.
module tb_rotate_seq_unit;

    localparam int W  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  data_in;
    logic          dir;
    logic [AW-1:0] amount;
    logic          out_ready;
    logic          busy;
    logic          out_valid;
    logic [W-1:0]  data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rotate_seq_unit #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .dir      (dir),
        .amount   (amount),
        .out_ready(out_ready),
        .busy     (busy),
        .out_valid(out_valid),
        .data_out (data_out)
    );

    // Reference: rotate by k as one arithmetic shift/or
    function automatic logic [W-1:0] model_rot(input logic [W-1:0] x, input logic left, input int k);
        int m;
        m = k % W;
        if (m == 0) return x;
        if (left) return (x << m) | (x >> (W - m));
        return (x >> m) | (x << (W - m));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; returns cycles until out_valid and a count of
    // cycles where busy dropped or data_out was nonzero before the result.
    task automatic run_op(input logic [W-1:0] d, input logic dr, input int amt, input logic rdy,
                          output int lat, output int glitches);
        data_in   = d;
        dir       = dr;
        amount    = amt[AW-1:0];
        out_ready = rdy;
        start     = 1'b1;
        tick();
        start    = 1'b0;
        lat      = 1;
        glitches = 0;
        while (!out_valid && lat < 40) begin
            if (!busy || data_out !== '0) glitches++;
            data_in = W'($urandom);
            dir     = 1'($urandom);
            amount  = AW'($urandom);
            start   = 1'($urandom);
            tick();
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; data_in = 8'hA5; dir = 1'b1; amount = 3'd2; out_ready = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset: busy=%b out_valid=%b data_out=%h, required 0 0 00", busy, out_valid, data_out);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: busy=%b out_valid=%b, required 0 0", busy, out_valid);
        end
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_directed;
        logic [W-1:0] tbl_d   [4] = '{8'hB4, 8'hB4, 8'h01, 8'h5A};
        logic         tbl_dir [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int           tbl_amt [4] = '{3, 1, 7, 0};
        logic [W-1:0] tbl_exp [4] = '{8'h96, 8'h69, 8'h80, 8'h5A};
        int lat, gl;
        for (int i = 0; i < 4; i++) begin
            run_op(tbl_d[i], tbl_dir[i], tbl_amt[i], 1'b1, lat, gl);
            checks++;
            if (lat != tbl_amt[i] + 1 || gl != 0) begin
                errors++;
                $display("FAIL directed_latency[%0d]: latency=%0d glitches=%0d, required %0d 0", i, lat, gl, tbl_amt[i] + 1);
            end
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || data_out !== tbl_exp[i]) begin
                errors++;
                $display("FAIL directed_data[%0d]: valid=%b busy=%b data_out=%h, required 1 1 %h", i, out_valid, busy, data_out, tbl_exp[i]);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00) begin
                errors++;
                $display("FAIL directed_idle[%0d]: valid=%b busy=%b data_out=%h, required 0 0 00", i, out_valid, busy, data_out);
            end
        end
    endtask

    task automatic test_random;
        int lat, gl, amt;
        logic [W-1:0] d, exp_v;
        logic dr;
        for (int i = 0; i < 40; i++) begin
            d     = W'($urandom);
            dr    = 1'($urandom);
            amt   = $urandom_range(0, W - 1);
            exp_v = model_rot(d, dr, amt);
            run_op(d, dr, amt, 1'b1, lat, gl);
            checks++;
            if (lat != amt + 1 || gl != 0 || data_out !== exp_v) begin
                errors++;
                $display("FAIL random[%0d]: d=%h dir=%b amt=%0d got lat=%0d gl=%0d data=%h, required lat=%0d gl=0 data=%h",
                         i, d, dr, amt, lat, gl, data_out, amt + 1, exp_v);
            end
            tick();
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL random_idle[%0d]: busy=%b valid=%b, required 0 0", i, busy, out_valid);
            end
        end
    endtask

    task automatic test_hold_and_back_to_back;
        int lat, gl;
        run_op(8'hB4, 1'b0, 3, 1'b0, lat, gl);
        checks++;
        if (lat != 4 || data_out !== 8'h96) begin
            errors++;
            $display("FAIL hold_first: lat=%0d data=%h, required 4 96", lat, data_out);
        end
        for (int i = 0; i < 5; i++) begin
            data_in = 8'hFF; start = 1'b1; dir = 1'($urandom); amount = AW'($urandom);
            tick();
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || data_out !== 8'h96) begin
                errors++;
                $display("FAIL hold[%0d]: valid=%b busy=%b data=%h, required 1 1 96", i, out_valid, busy, data_out);
            end
        end
        data_in = 8'hFF; dir = 1'b0; amount = 3'd0; start = 1'b1; out_ready = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL complete_start_ignored: busy=%b valid=%b data=%h, required 0 0 00", busy, out_valid, data_out);
        end
        tick();
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'hFF) begin
            errors++;
            $display("FAIL back_to_back: valid=%b data=%h, required 1 ff", out_valid, data_out);
        end
        tick();
    endtask

    task automatic test_reset_abort;
        int lat, gl;
        data_in = 8'h33; dir = 1'b1; amount = 3'd5; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_abort: busy=%b valid=%b data=%h, required 0 0 00", busy, out_valid, data_out);
        end
        run_op(8'h0F, 1'b0, 4, 1'b1, lat, gl);
        checks++;
        if (lat != 5 || gl != 0 || data_out !== 8'hF0) begin
            errors++;
            $display("FAIL after_abort: lat=%0d gl=%0d data=%h, required 5 0 f0", lat, gl, data_out);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data_in = '0; dir = 1'b0; amount = '0; out_ready = 1'b0;
        tick();
        test_reset();
        test_directed();
        test_random();
        test_hold_and_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
